// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the pipelined data memory.
// DMEM_CLEAR_EN selects the post-reset clear sweep in dmem_pipe.
package dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_DEPTH  = 256;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the load/store unit (master) and dmem_pipe (slave).
interface dmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  localparam int STRB_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port storage, one byte-wide RAM per lane so each lane has its own write enable.
// Read data is registered and only changes on a read enable.
module dmem_array #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;

      always_ff @(posedge clk) begin
        if (wr_strb[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
        if (rd_en) begin
          lane_q <= lane_mem[addr];
        end
      end

      assign rdata[gi*8 +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_pipe.sv
// Data memory with valid/ready request channel and a one-deep registered response.
// Define DMEM_CLEAR_EN to zero the whole array in a sweep after every reset.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter  int DATA_W = DMEM_DATA_W,
  parameter  int DEPTH  = DMEM_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  logic              run;
  logic              accept;
  logic              in_range;

  logic              ram_rd_en;
  logic [STRB_W-1:0] ram_wr_strb;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg,   rsp_err_next;
  logic              rsp_data_reg,  rsp_data_next;

`ifdef DMEM_CLEAR_EN
  state_e            state_reg,   state_next;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    if (state_reg == ST_CLEAR) begin
      clr_cnt_next = clr_cnt_reg + 1'b1;
      if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
        state_next   = ST_RUN;
        clr_cnt_next = '0;
      end
    end
  end

  assign run = (state_reg == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // Only rsp_ready reaches req_ready combinationally; req_valid never does.
  assign bus.req_ready = run && (!rsp_valid_reg || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_range      = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);

  always_comb begin
    ram_addr    = bus.req_addr;
    ram_wdata   = bus.req_wdata;
    ram_rd_en   = accept && !bus.req_we && in_range;
    ram_wr_strb = (accept && bus.req_we && in_range) ? bus.req_strb : '0;
`ifdef DMEM_CLEAR_EN
    if (!run) begin
      ram_addr    = clr_cnt_reg;
      ram_wdata   = '0;
      ram_wr_strb = '1;
    end
`endif
    // A write coinciding with reset assertion must not land in the array.
    if (!rst_n) begin
      ram_rd_en   = 1'b0;
      ram_wr_strb = '0;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .wr_strb (ram_wr_strb),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_comb begin
    rsp_valid_next = rsp_valid_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_data_next  = rsp_data_reg;
    if (accept) begin
      rsp_valid_next = 1'b1;
      rsp_err_next   = !in_range;
      rsp_data_next  = !bus.req_we && in_range;
    end else if (bus.rsp_ready) begin
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  // The RAM output register holds until the next accepted read, so it doubles as the response data.
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rsp_data_reg ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: a 256-word instance and a 200-word instance sharing clock and reset.
module tb_dmem_pipe;

`ifdef DMEM_CLEAR_EN
  localparam int RISE_A = 256;
  localparam int RISE_B = 200;
`else
  localparam int RISE_A = 0;
  localparam int RISE_B = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_strb;
  logic        rsp_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
  dmem_if #(.DATA_W(16), .ADDR_W(8)) bus_b ();

  assign bus_a.req_valid = req_valid & ~sel;
  assign bus_b.req_valid = req_valid & sel;
  assign bus_a.req_we    = req_we;
  assign bus_b.req_we    = req_we;
  assign bus_a.req_addr  = req_addr;
  assign bus_b.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_wdata = req_wdata;
  assign bus_a.req_strb  = req_strb;
  assign bus_b.req_strb  = req_strb;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.rsp_ready = rsp_ready;

  wire        o_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  wire        o_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  wire        o_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
  wire [15:0] o_rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;

  dmem_pipe #(.DATA_W(16), .DEPTH(256)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  dmem_pipe #(.DATA_W(16), .DEPTH(200)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic idle();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic xact(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                      input logic [1:0] strb, output logic [15:0] rd, output logic err,
                      output logic vld);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_strb = strb;
    rsp_ready = 1'b1;
    while (!o_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      vectors++; miscompares++;
      $display("FAIL xact_timeout addr=%0h: req_ready got 0, required 1", addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd = o_rdata; err = o_err; vld = o_valid;
    $display("xact sel=%0d we=%0d addr=%0h wd=%h strb=%b -> vld=%0d rd=%h err=%0d",
             sel, we, addr, wd, strb, vld, rd, err);
  endtask

  task automatic measure_clear(input string tag);
    int rise_a = -1;
    int rise_b = -1;
    for (int c = 0; c <= 300; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (rise_a < 0 && bus_a.req_ready) rise_a = c;
      if (rise_b < 0 && bus_b.req_ready) rise_b = c;
    end
    vectors++;
    if (rise_a !== RISE_A) begin
      miscompares++;
      $display("FAIL %s_rise_256: req_ready rose after %0d cycles, required %0d", tag, rise_a, RISE_A);
    end
    vectors++;
    if (rise_b !== RISE_B) begin
      miscompares++;
      $display("FAIL %s_rise_200: req_ready rose after %0d cycles, required %0d", tag, rise_b, RISE_B);
    end
    $display("%s: ready rise 256=%0d 200=%0d", tag, rise_a, rise_b);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({o_valid, o_err, o_rdata} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid/err/rdata got %b/%b/%h, required 0/0/0000", o_valid, o_err, o_rdata);
    end
`ifdef DMEM_CLEAR_EN
    vectors++;
    if (o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 0", o_ready);
    end
`endif
    rst_n = 1'b1;
    measure_clear("reset");
  endtask

  task automatic test_clear_read();
    logic [15:0] rd; logic err; logic vld;
`ifdef DMEM_CLEAR_EN
    sel = 1'b0;
    xact(1'b0, 8'hFF, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL clear_read_ff: vld/err/rd got %b/%b/%h, required 1/0/0000", vld, err, rd);
    end
    sel = 1'b1;
    xact(1'b0, 8'd199, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL clear_read_199: vld/err/rd got %b/%b/%h, required 1/0/0000", vld, err, rd);
    end
    sel = 1'b0;
`else
    rd = '0; err = 1'b0; vld = 1'b0;
    $display("clear sweep not built, rd=%h err=%0d vld=%0d", rd, err, vld);
`endif
  endtask

  task automatic test_strobe();
    logic [15:0] rd; logic err; logic vld;
    sel = 1'b0;
    xact(1'b1, 8'h10, 16'hBEEF, 2'b11, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL write_rsp: vld/err/rd got %b/%b/%h, required 1/0/0000", vld, err, rd);
    end
    xact(1'b1, 8'h10, 16'h12AB, 2'b10, rd, err, vld);
    xact(1'b0, 8'h10, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, 16'h12EF}) begin
      miscompares++;
      $display("FAIL strb_hi: vld/err/rd got %b/%b/%h, required 1/0/12ef", vld, err, rd);
    end
    xact(1'b1, 8'h10, 16'hFFFF, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL strb_zero_rsp: vld/err got %b/%b, required 1/0", vld, err);
    end
    xact(1'b0, 8'h10, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if (rd !== 16'h12EF) begin
      miscompares++;
      $display("FAIL strb_zero_mem: rd got %h, required 12ef", rd);
    end
    xact(1'b1, 8'h10, 16'h5634, 2'b01, rd, err, vld);
    xact(1'b0, 8'h10, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if (rd !== 16'h1234) begin
      miscompares++;
      $display("FAIL strb_lo: rd got %h, required 1234", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic err; logic vld;
    logic        we_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  addr_t[6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
    logic [15:0] wd_t  [6] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hCAFE, 16'h0};
    logic [15:0] exp_t [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000, 16'hCAFE};
    sel = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      xact(1'b1, 8'(k), 16'(16'h1111 * k), 2'b11, rd, err, vld);
    end
    idle();
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_we = we_t[i]; req_addr = addr_t[i];
      req_wdata = wd_t[i]; req_strb = 2'b11;
      vectors++;
      if (o_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %b, required 1", i, o_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if ({o_valid, o_rdata} !== {1'b1, exp_t[i]}) begin
        miscompares++;
        $display("FAIL b2b_rsp[%0d]: vld/rd got %b/%h, required 1/%h", i, o_valid, o_rdata, exp_t[i]);
      end
      $display("b2b[%0d] we=%0d addr=%0d -> vld=%0d rd=%h", i, we_t[i], addr_t[i], o_valid, o_rdata);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: rsp_valid got %b, required 0", o_valid);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    idle();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_strb = 2'b00;
    @(posedge clk); #1;
    req_addr = 8'd2;
    vectors++;
    if ({o_valid, o_rdata} !== {1'b1, 16'h1234}) begin
      miscompares++;
      $display("FAIL bp_first: vld/rd got %b/%h, required 1/1234", o_valid, o_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({o_ready, o_valid, o_rdata} !== {1'b0, 1'b1, 16'h1234}) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: ready/vld/rd got %b/%b/%h, required 0/1/1234", i, o_ready, o_valid, o_rdata);
      end
      $display("bp stall %0d: ready=%0d rd=%h", i, o_ready, o_rdata);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b, required 1", o_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if ({o_valid, o_rdata} !== {1'b1, 16'h2222}) begin
      miscompares++;
      $display("FAIL bp_queued: vld/rd got %b/%h, required 1/2222", o_valid, o_rdata);
    end
    @(posedge clk); #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_consume: rsp_valid got %b, required 0", o_valid);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic err; logic vld;
    sel = 1'b1;
    idle();
    xact(1'b1, 8'd199, 16'h1234, 2'b11, rd, err, vld);
    vectors++;
    if ({vld, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_write_199: vld/err got %b/%b, required 1/0", vld, err);
    end
    xact(1'b1, 8'd210, 16'h5555, 2'b11, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL oor_write_210: vld/err/rd got %b/%b/%h, required 1/1/0000", vld, err, rd);
    end
    xact(1'b0, 8'd210, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b1, 16'h0000}) begin
      miscompares++;
      $display("FAIL oor_read_210: vld/err/rd got %b/%b/%h, required 1/1/0000", vld, err, rd);
    end
    xact(1'b0, 8'd199, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, 16'h1234}) begin
      miscompares++;
      $display("FAIL oor_read_199: vld/err/rd got %b/%b/%h, required 1/0/1234", vld, err, rd);
    end
    sel = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic err; logic vld;
    logic [15:0] exp_rd;
    sel = 1'b0;
    idle();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if ({o_valid, o_rdata} !== {1'b1, 16'h3333}) begin
      miscompares++;
      $display("FAIL mid_pending: vld/rd got %b/%h, required 1/3333", o_valid, o_rdata);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_err, o_rdata} !== 18'h0) begin
      miscompares++;
      $display("FAIL mid_reset_rsp: vld/err/rd got %b/%b/%h, required 0/0/0000", o_valid, o_err, o_rdata);
    end
`ifdef DMEM_CLEAR_EN
    vectors++;
    if (o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_ready: got %b, required 0", o_ready);
    end
    exp_rd = 16'h0000;
`else
    exp_rd = 16'h1234;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    measure_clear("mid_reset");
    xact(1'b0, 8'h10, 16'h0, 2'b00, rd, err, vld);
    vectors++;
    if ({vld, err, rd} !== {1'b1, 1'b0, exp_rd}) begin
      miscompares++;
      $display("FAIL mid_reset_read: vld/err/rd got %b/%b/%h, required 1/0/%h", vld, err, rd, exp_rd);
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_clear_read();
    test_strobe();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
